// File: rtl/riscv_pkg.sv
// Shared load/store encodings and LSU state type, common to the decoder and the LSU.
package riscv_pkg;

   localparam logic [2:0] LSU_B  = 3'b000;
   localparam logic [2:0] LSU_H  = 3'b001;
   localparam logic [2:0] LSU_W  = 3'b010;
   localparam logic [2:0] LSU_BU = 3'b100;
   localparam logic [2:0] LSU_HU = 3'b101;

   typedef enum logic [1:0] {
      LSU_IDLE,
      LSU_BUS,
      LSU_DONE
   } lsu_state_t;

endpackage

// File: rtl/riscv_lsu_align.sv
// Lane steering for a 32-bit data bus: byte enables, store replication, load extract/extend.
module riscv_lsu_align
   import riscv_pkg::*;
(
   input  logic [2:0]  size,
   input  logic [1:0]  addr_lo,
   input  logic [31:0] wd,
   input  logic [31:0] rd,
   output logic [3:0]  be,
   output logic [31:0] wd_lane,
   output logic [31:0] rd_ext,
   output logic        misaligned
);

   logic [7:0]  rd_byte;
   logic [15:0] rd_half;

   always_comb begin
      case (addr_lo)
         2'd0:    rd_byte = rd[7:0];
         2'd1:    rd_byte = rd[15:8];
         2'd2:    rd_byte = rd[23:16];
         default: rd_byte = rd[31:24];
      endcase
      rd_half = addr_lo[1] ? rd[31:16] : rd[15:0];
   end

   // Undefined size encodings fall through to the word case.
   always_comb begin
      be         = 4'b1111;
      wd_lane    = wd;
      rd_ext     = rd;
      misaligned = 1'b0;
      case (size)
         LSU_B, LSU_BU: begin
            be      = 4'b0001 << addr_lo;
            wd_lane = {4{wd[7:0]}};
            rd_ext  = (size == LSU_B) ? {{24{rd_byte[7]}}, rd_byte} : {24'h0, rd_byte};
         end
         LSU_H, LSU_HU: begin
            be         = addr_lo[1] ? 4'b1100 : 4'b0011;
            wd_lane    = {2{wd[15:0]}};
            rd_ext     = (size == LSU_H) ? {{16{rd_half[15]}}, rd_half} : {16'h0, rd_half};
            misaligned = addr_lo[0];
         end
         default: begin
            misaligned = |addr_lo;
         end
      endcase
   end

endmodule

// File: rtl/riscv_lsu.sv
// Load/store unit: turns a core memory request into one req/ack bus transaction and stalls the core.
//
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   LSU_IDLE | waiting for an aligned core request; bus idle
//   LSU_BUS  | bus_req_o held with stable fields until ack or timeout
//   LSU_DONE | result valid, stall released; core request ignored
module riscv_lsu
   import riscv_pkg::*;
#(
   parameter int ADDR_W         = 32,
   parameter int TIMEOUT_CYCLES = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              core_req_i,
   input  logic              core_we_i,
   input  logic [2:0]        core_size_i,
   input  logic [31:0]       core_addr_i,
   input  logic [31:0]       core_wd_i,
   output logic [31:0]       core_rd_o,
   output logic              core_stall_o,
   output logic              misaligned_o,
   output logic              bus_err_o,
   output logic              bus_req_o,
   output logic              bus_we_o,
   output logic [3:0]        bus_be_o,
   output logic [ADDR_W-1:0] bus_addr_o,
   output logic [31:0]       bus_wd_o,
   input  logic [31:0]       bus_rd_i,
   input  logic              bus_ack_i
);

   localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

   lsu_state_t       state;
   logic [2:0]       size_q;
   logic [1:0]       addr_lo_q;
   logic [CNT_W-1:0] cnt;

   logic [2:0]  sel_size;
   logic [1:0]  sel_addr_lo;
   logic [3:0]  be;
   logic [31:0] wd_lane;
   logic [31:0] rd_ext;
   logic        misaligned;
   logic        timeout_hit;

   // In IDLE the aligner looks at the live request; afterwards at the latched access.
   assign sel_size    = (state == LSU_IDLE) ? core_size_i : size_q;
   assign sel_addr_lo = (state == LSU_IDLE) ? core_addr_i[1:0] : addr_lo_q;

   riscv_lsu_align u_align (
      .size       (sel_size),
      .addr_lo    (sel_addr_lo),
      .wd         (core_wd_i),
      .rd         (bus_rd_i),
      .be         (be),
      .wd_lane    (wd_lane),
      .rd_ext     (rd_ext),
      .misaligned (misaligned)
   );

   assign misaligned_o = (state == LSU_IDLE) && core_req_i && misaligned;
   assign core_stall_o = ((state == LSU_IDLE) && core_req_i && !misaligned) || (state == LSU_BUS);
   assign timeout_hit  = (TIMEOUT_CYCLES != 0) && (int'(cnt) == TIMEOUT_CYCLES - 1);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state      <= LSU_IDLE;
         size_q     <= LSU_W;
         addr_lo_q  <= 2'b00;
         cnt        <= '0;
         bus_req_o  <= 1'b0;
         bus_we_o   <= 1'b0;
         bus_be_o   <= 4'b0000;
         bus_addr_o <= '0;
         bus_wd_o   <= 32'h0;
         core_rd_o  <= 32'h0;
         bus_err_o  <= 1'b0;
      end else begin
         bus_err_o <= 1'b0;
         case (state)
            LSU_IDLE: begin
               if (core_req_i && !misaligned) begin
                  state      <= LSU_BUS;
                  size_q     <= core_size_i;
                  addr_lo_q  <= core_addr_i[1:0];
                  cnt        <= '0;
                  bus_req_o  <= 1'b1;
                  bus_we_o   <= core_we_i;
                  bus_be_o   <= be;
                  bus_addr_o <= {core_addr_i[ADDR_W-1:2], 2'b00};
                  bus_wd_o   <= wd_lane;
               end
            end
            LSU_BUS: begin
               // Ack wins over a timeout landing in the same cycle.
               if (bus_ack_i) begin
                  state     <= LSU_DONE;
                  bus_req_o <= 1'b0;
                  if (!bus_we_o) begin
                     core_rd_o <= rd_ext;
                  end
               end else if (timeout_hit) begin
                  state     <= LSU_DONE;
                  bus_req_o <= 1'b0;
                  core_rd_o <= 32'h0;
                  bus_err_o <= 1'b1;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            LSU_DONE: begin
               state <= LSU_IDLE;
            end
            default: begin
               state <= LSU_IDLE;
            end
         endcase
      end
   end

endmodule

// File: doc/riscv_lsu.md
# riscv_lsu

Parametrised load/store unit between the single-cycle RISC-V datapath and a data-memory bus with variable latency. Takes the decoder's memory request (req, we, size), the ALU address and RS2 data, and produces byte-enabled, lane-aligned bus transactions over a req/ack handshake. Returns sign- or zero-extended load data and stalls the core (freezes PC and register writeback) until the access completes. Adds misalignment detection and a bus timeout, which the current flat DataMemory hookup lacks.

## Interface
Parameters:
- ADDR_W, 32, bus address width; core address bits above ADDR_W are ignored.
- TIMEOUT_CYCLES, 16, maximum BUS-state cycles without ack before bus error; 0 disables the timeout.

Ports:
- clk  in  1  single clock, rising edge
- reset  in  1  asynchronous, active-high
- core_req_i  in  1  memory instruction in execute (decoder mem_req)
- core_we_i  in  1  1 = store (decoder mem_we)
- core_size_i  in  3  funct3: 000 B, 001 H, 010 W, 100 BU, 101 HU
- core_addr_i  in  32  byte address (ALU result)
- core_wd_i  in  32  store data (RS2)
- core_rd_o  out  32  extended load data, valid in DONE
- core_stall_o  out  1  hold PC and GPR write
- misaligned_o  out  1  access aborted for misalignment
- bus_err_o  out  1  one-cycle pulse on timeout
- bus_req_o  out  1  bus request, registered
- bus_we_o  out  1  bus write
- bus_be_o  out  4  byte enables
- bus_addr_o  out  ADDR_W  word-aligned address (bits [1:0] = 0)
- bus_wd_o  out  32  lane-replicated store data
- bus_rd_i  in  32  read word
- bus_ack_i  in  1  completion; 1 cycle, valid only while bus_req_o=1

## Operation
- FSM states: IDLE, BUS, DONE.
- IDLE: if core_req_i and aligned, latch we/size/addr/wd; go to BUS. If misaligned (H with addr[0]=1, W with addr[1:0]≠0), stay in IDLE, assert misaligned_o combinationally, issue no bus access, keep stall low.
- BUS: hold bus_req_o and all bus_* fields stable until bus_ack_i. On ack, capture the extended load result and go to DONE. On timeout, set bus_err_o, load result = 0, go to DONE.
- DONE: unconditional return to IDLE. core_req_i is ignored here, so the still-asserted request of the same instruction is not reissued.
- Byte enables: B → 0001 << addr[1:0]; H → 0011 << {addr[1],0}; W → 1111.
- Store data: B replicated ×4; H replicated ×2; W as is.
- Load: select byte or half by addr[1:0]. B/H are sign-extended, BU/HU are zero-extended. Sizes 011/110/111 are treated as W.
- bus_ack_i outside BUS is ignored.

## Timing
- Reset values: state IDLE; bus_req_o, bus_we_o, bus_be_o, bus_addr_o, bus_wd_o, core_rd_o, bus_err_o all 0; timeout counter 0.
- core_stall_o = (state==IDLE & core_req_i & aligned) | state==BUS. It is combinational, so the request cycle itself is stalled.
- Request in cycle T → bus_req_o high from T+1.
- Ack in cycle A → DONE in A+1: stall low, core_rd_o valid, PC advances at the end of A+1.
- Zero-wait memory (ack in T+1) gives a 3-cycle instruction.
- Timeout counter clears on BUS entry. bus_err_o pulses in the cycle DONE is entered after TIMEOUT_CYCLES BUS cycles without ack.
- Ack in the same cycle as the counter reaching its limit counts as success; no error.
- Asynchronous reset in any state forces the reset values immediately; bus_req_o drops without waiting for ack.

## Structure
- Package riscv_pkg:
  - size encodings LSU_B/H/W/BU/HU
  - lsu_state_t enum
  - shared with decoder_riscv
- Sub-module riscv_lsu_align (combinational): byte enables, store replication and load extraction/extension. Reused by a future pipelined core.

## Test plan
- SW addr 0x0000_0010, wd 0xDEADBEEF, ack after 2 wait cycles → be=1111, addr 0x10, wd 0xDEADBEEF; stall for 4 cycles; no reissue in DONE.
- SB addr 0x13, wd 0x000000A5 → be=1000, wd 0xA5A5A5A5.
- LB addr 0x11, bus_rd 0x0080FF00 → core_rd 0xFFFFFFFF. LBU same → 0x000000FF. LH addr 0x12 → 0x00000080.
- LW addr 0x06 → misaligned_o=1, bus_req_o never rises, stall low; SH addr 0x05 also aborts, no write.
- TIMEOUT_CYCLES=4, no ack → bus_err_o pulse after 4 BUS cycles, core_rd_o=0. Ack on cycle 4 → no error.
- Reset asserted mid-BUS → bus_req_o=0 immediately; a late ack after release is ignored, state stays IDLE.
